ctrl_ramdrv_coefgen: RTL and testbench
======================================

CTRL_RAMDRV_COEFGEN -- requirements
Module: ctrl_ramdrv_coefgen

Interface
REQ-001 SHALL have parameter DATA_ADDRESS_WIDTH, default 12, coefficient RAM address width (AW).
REQ-002 SHALL have parameter CHANNELS, default 4, number of independent coefficient channels (>=2); channel-index width CW = clog2(CHANNELS), derived internally.
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 clr  in  1  reset, asynchronous, active-high.
REQ-005 load  in  1  write channel table entry ch_sel.
REQ-006 start  in  1  begin one coefficient sweep on channel ch_sel.
REQ-007 ch_sel  in  CW  channel select for load/start.
REQ-008 coef_ptr  in  AW  ring base address (written on load).
REQ-009 coef_len  in  AW  ring length in taps (written on load).
REQ-010 coef_step  in  AW  phase advance per completed sweep (written on load).
REQ-011 cnt_en  in  1  advance enable; low stalls the sweep.
REQ-012 coef_addr  out  AW  coefficient RAM address.
REQ-013 addr_vld  out  1  coef_addr valid this cycle.
REQ-014 busy  out  1  sweep in progress.
REQ-015 done  out  1  one-cycle end-of-sweep pulse (ring-buffer count-end flag).
REQ-016 cur_ch  out  CW  channel of current/last sweep.

Function
REQ-017 Per channel: table registers base, len, step (AW each) and phase offset (AW); load writes base/len/step from inputs and clears phase of ch_sel, in any state.
REQ-018 FSM states: IDLE, RUN; IDLE->RUN on start (len!=0); RUN->IDLE after last tap; start ignored in RUN.
REQ-019 On start in IDLE: snapshot base/len of ch_sel into active registers, off <= phase[ch_sel], tap <= 0, cur_ch <= ch_sel, busy=1 from next cycle.
REQ-020 Load during RUN (any channel, incl. cur_ch) SHALL NOT affect the active sweep; new values apply from the next start.
REQ-021 coef_addr = active_base + off, modulo 2^AW; addr_vld = RUN & cnt_en; no latency beyond the RUN state (combinational from registers).
REQ-022 In RUN with cnt_en=1: tap <= tap+1; off <= (off==len-1) ? 0 : off+1 (ring wrap inside [base, base+len-1]); cnt_en=0 holds all counters.
REQ-023 When tap==len-1 and cnt_en=1: next cycle state=IDLE, busy=0, done=1 for exactly one cycle, phase[cur_ch] <= phase+step, minus len if result >= len (single conditional subtract; step<len required, step>=len result unspecified).
REQ-024 Start in IDLE with len[ch_sel]==0: no RUN, no addr_vld; done pulses next cycle; phase unchanged.
REQ-025 Simultaneous load and start on same channel in IDLE: start uses pre-load table values; load takes effect afterwards.
REQ-026 A new start is accepted in the cycle done is high (back-to-back sweeps, no idle gap required).
REQ-027 Exactly len addresses SHALL be issued per sweep, each with addr_vld=1.

Reset
REQ-028 clr=1 asynchronously forces IDLE; busy, done, addr_vld, cur_ch, tap, off, active registers and all table entries to 0; coef_addr per REQ-030/031.
REQ-029 clr asserted mid-sweep SHALL abort it with no done pulse; first start after release behaves as from power-up.

Configuration
REQ-030 Macro COEFGEN_TRISTATE_EN defined: coef_addr SHALL be high-impedance whenever addr_vld=0 (shared RAM address bus).
REQ-031 Macro undefined: coef_addr SHALL drive all-zeros whenever addr_vld=0; behaviour otherwise identical.

Verification
REQ-032 Load ch1 base=0x100,len=4,step=1; start ch1, cnt_en=1 -> addresses 0x100,0x101,0x102,0x103, done pulse next cycle.
REQ-033 Repeat start ch1 -> 0x101,0x102,0x103,0x100 (phase=1, wrap); third sweep starts at 0x102.
REQ-034 Base=0xFFE,len=4,step=0 -> 0xFFE,0xFFF,0x000,0x001 (AW modulo wrap).
REQ-035 During ch1 sweep toggle cnt_en 1,0,0,1 and load ch1 len=8 -> still 4 addresses, stall cycles addr_vld=0, next sweep 8 taps.
REQ-036 Assert clr after 2nd address -> busy=0, no done, table cleared; start ch1 -> immediate done (len=0), no addr_vld.
REQ-037 Run twice: with COEFGEN_TRISTATE_EN -> coef_addr=Z when idle; without -> 0x000 when idle.

Source files
------------

// File: rtl/ctrl_ramdrv_coefgen.sv
// Multi-channel coefficient RAM address generator: each start sweeps one channel's ring of taps.
// Define COEFGEN_TRISTATE_EN to float coef_addr when no address is valid (shared bus).
module ctrl_ramdrv_coefgen #(
    parameter int unsigned DATA_ADDRESS_WIDTH = 12,
    parameter int unsigned CHANNELS           = 4
) (
    input  logic                                clk,
    input  logic                                clr,
    input  logic                                load,
    input  logic                                start,
    input  logic [$clog2(CHANNELS)-1:0]         ch_sel,
    input  logic [DATA_ADDRESS_WIDTH-1:0]       coef_ptr,
    input  logic [DATA_ADDRESS_WIDTH-1:0]       coef_len,
    input  logic [DATA_ADDRESS_WIDTH-1:0]       coef_step,
    input  logic                                cnt_en,
    output logic [DATA_ADDRESS_WIDTH-1:0]       coef_addr,
    output logic                                addr_vld,
    output logic                                busy,
    output logic                                done,
    output logic [$clog2(CHANNELS)-1:0]         cur_ch
);
    localparam int unsigned AW = DATA_ADDRESS_WIDTH;
    localparam int unsigned CW = $clog2(CHANNELS);
    localparam logic [AW-1:0] AddrOne = AW'(1);

    typedef enum logic {StIdle, StRun} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   base_q  [CHANNELS];
    logic [AW-1:0]   len_q   [CHANNELS];
    logic [AW-1:0]   step_q  [CHANNELS];
    logic [AW-1:0]   phase_q [CHANNELS];
    logic [AW-1:0]   abase_q, alen_q, astep_q, off_q, tap_q;
    logic [CW-1:0]   cur_ch_q;
    logic            done_q;

    logic            accept, advance, last_tap, sweep_end;
    logic [AW:0]     phase_sum;
    logic [AW-1:0]   phase_next, addr_sum;

    assign accept    = (state_q == StIdle) && start;
    assign advance   = (state_q == StRun) && cnt_en;
    assign last_tap  = (tap_q == alen_q - AddrOne);
    assign sweep_end = advance && last_tap;

    // Phase advances once per completed sweep and stays inside [0, len-1].
    assign phase_sum  = {1'b0, phase_q[cur_ch_q]} + {1'b0, astep_q};
    assign phase_next = (phase_sum >= {1'b0, alen_q}) ? AW'(phase_sum - {1'b0, alen_q})
                                                      : phase_sum[AW-1:0];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start && (len_q[ch_sel] != '0)) state_d = StRun;
            StRun:  if (sweep_end) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= StIdle;
            abase_q  <= '0;
            alen_q   <= '0;
            astep_q  <= '0;
            off_q    <= '0;
            tap_q    <= '0;
            cur_ch_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            if (accept) begin
                abase_q  <= base_q[ch_sel];
                alen_q   <= len_q[ch_sel];
                astep_q  <= step_q[ch_sel];
                off_q    <= phase_q[ch_sel];
                tap_q    <= '0;
                cur_ch_q <= ch_sel;
                if (len_q[ch_sel] == '0) done_q <= 1'b1;
            end
            if (advance) begin
                tap_q <= tap_q + AddrOne;
                off_q <= (off_q == alen_q - AddrOne) ? '0 : off_q + AddrOne;
                if (last_tap) done_q <= 1'b1;
            end
        end
    end

    // Table writes come after the phase update so a same-cycle load wins.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                base_q[i]  <= '0;
                len_q[i]   <= '0;
                step_q[i]  <= '0;
                phase_q[i] <= '0;
            end
        end else begin
            if (sweep_end) phase_q[cur_ch_q] <= phase_next;
            if (load) begin
                base_q[ch_sel]  <= coef_ptr;
                len_q[ch_sel]   <= coef_len;
                step_q[ch_sel]  <= coef_step;
                phase_q[ch_sel] <= '0;
            end
        end
    end

    assign addr_vld = advance;
    assign busy     = (state_q == StRun);
    assign done     = done_q;
    assign cur_ch   = cur_ch_q;
    assign addr_sum = abase_q + off_q;

`ifdef COEFGEN_TRISTATE_EN
    assign coef_addr = addr_vld ? addr_sum : 'z;
`else
    assign coef_addr = addr_vld ? addr_sum : '0;
`endif

endmodule

// File: tb/tb_ctrl_ramdrv_coefgen.sv
// Bench for ctrl_ramdrv_coefgen: directed scenarios then random traffic vs an address-queue model.
module tb_ctrl_ramdrv_coefgen;
    localparam int AW = 12;
    localparam int CH = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          clr;
    logic          load, start, cnt_en;
    logic [CW-1:0] ch_sel;
    logic [AW-1:0] coef_ptr, coef_len, coef_step;
    logic [AW-1:0] coef_addr;
    logic          addr_vld, busy, done;
    logic [CW-1:0] cur_ch;

    int checks = 0;
    int failures = 0;

    // Reference model: channel tables plus the queue of addresses still owed by the sweep.
    int base_t[CH], len_t[CH], step_t[CH], phase_t[CH];
    int exp_q[$];
    int cur_m, alen_m, astep_m;
    bit done_m;
    logic [31:0] idle_val;

    ctrl_ramdrv_coefgen #(.DATA_ADDRESS_WIDTH(AW), .CHANNELS(CH)) dut (
        .clk(clk), .clr(clr), .load(load), .start(start), .ch_sel(ch_sel),
        .coef_ptr(coef_ptr), .coef_len(coef_len), .coef_step(coef_step), .cnt_en(cnt_en),
        .coef_addr(coef_addr), .addr_vld(addr_vld), .busy(busy), .done(done), .cur_ch(cur_ch)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            base_t[i] = 0; len_t[i] = 0; step_t[i] = 0; phase_t[i] = 0;
        end
        exp_q.delete();
        cur_m = 0; alen_m = 0; astep_m = 0; done_m = 0;
    endtask

    // One clock: drive at negedge, check, advance the model to the next posedge.
    task automatic step(input bit ld, input bit st, input int ch, input int ptr,
                        input int len, input int stp, input bit en);
        bit b, done_n;
        @(negedge clk);
        load = ld; start = st; ch_sel = CW'(ch); cnt_en = en;
        coef_ptr = AW'(ptr); coef_len = AW'(len); coef_step = AW'(stp);
        #1;
        b = (exp_q.size() > 0);
        check_eq("busy", {31'b0, busy}, {31'b0, b});
        check_eq("addr_vld", {31'b0, addr_vld}, {31'b0, b && en});
        check_eq("done", {31'b0, done}, {31'b0, done_m});
        if (b) check_eq("cur_ch", {30'b0, cur_ch}, cur_m);
        if (b && en) check_eq("coef_addr", {20'b0, coef_addr}, exp_q[0]);
        else check_eq("coef_addr_idle", {20'b0, coef_addr}, idle_val);
        done_n = 0;
        if (b) begin
            if (en) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) begin
                    done_n = 1;
                    phase_t[cur_m] = phase_t[cur_m] + astep_m;
                    if (phase_t[cur_m] >= alen_m) phase_t[cur_m] -= alen_m;
                end
            end
        end else if (st) begin
            cur_m = ch;
            if (len_t[ch] == 0) done_n = 1;
            else begin
                alen_m = len_t[ch];
                astep_m = step_t[ch];
                for (int k = 0; k < alen_m; k++)
                    exp_q.push_back((base_t[ch] + (phase_t[ch] + k) % alen_m) % (1 << AW));
            end
        end
        if (ld) begin
            base_t[ch] = ptr; len_t[ch] = len; step_t[ch] = stp; phase_t[ch] = 0;
        end
        done_m = done_n;
        @(posedge clk);
    endtask

    task automatic idle(input int n, input bit en);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, en);
    endtask

    task automatic go(input int ch);
        step(0, 1, ch, 0, 0, 0, 1);
    endtask

    task automatic setup(input int ch, input int ptr, input int len, input int stp);
        step(1, 0, ch, ptr, len, stp, 1);
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        #1;
        check_eq("clr_busy", {31'b0, busy}, 0);
        check_eq("clr_done", {31'b0, done}, 0);
        check_eq("clr_vld", {31'b0, addr_vld}, 0);
        check_eq("clr_cur_ch", {30'b0, cur_ch}, 0);
        model_reset();
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        int ch, len;
`ifdef COEFGEN_TRISTATE_EN
        idle_val = {20'b0, {AW{1'bz}}};
`else
        idle_val = 32'h0;
`endif
        clr = 1'b1; load = 0; start = 0; cnt_en = 0; ch_sel = '0;
        coef_ptr = '0; coef_len = '0; coef_step = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", {31'b0, busy}, 0);
        check_eq("rst_done", {31'b0, done}, 0);
        check_eq("rst_vld", {31'b0, addr_vld}, 0);
        check_eq("rst_cur_ch", {30'b0, cur_ch}, 0);
        check_eq("rst_addr", {20'b0, coef_addr}, idle_val);
        @(negedge clk);
        clr = 1'b0;

        // Ring sweep with phase advance; later starts land in the done cycle.
        setup(1, 'h100, 4, 1);
        go(1); idle(4, 1);
        go(1); idle(4, 1);
        go(1); idle(5, 1);

        // Address wraps modulo 2^AW.
        setup(2, 'hFFE, 4, 0);
        go(2); idle(5, 1);

        // Stalls and a mid-sweep reload of the active channel.
        go(1);
        step(0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 1, 'h100, 8, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        idle(4, 1);
        go(1); idle(9, 1);

        // Reset mid-sweep, then a zero-length start.
        go(1); idle(2, 1);
        do_clr();
        go(1); idle(2, 1);

        // Same-cycle load and start: the sweep uses the old table entry.
        setup(0, 'h200, 3, 1);
        step(1, 1, 0, 'h300, 5, 2, 1);
        idle(4, 1);
        go(0); idle(6, 1);

        for (int it = 0; it < 600; it++) begin
            ch = $urandom_range(0, CH - 1);
            len = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 8);
            if (exp_q.size() == 0) begin
                case ($urandom_range(0, 9))
                    0, 1, 2: step(1, 0, ch, $urandom_range(0, 4095), len,
                                  (len == 0) ? 0 : $urandom_range(0, len - 1), 1);
                    3, 4, 5, 6: step(0, 1, ch, 0, 0, 0, $urandom_range(0, 3) != 0);
                    default: idle(1, $urandom_range(0, 1));
                endcase
            end else if (ch != cur_m && $urandom_range(0, 5) == 0) begin
                step(1, 0, ch, $urandom_range(0, 4095), len,
                     (len == 0) ? 0 : $urandom_range(0, len - 1), $urandom_range(0, 3) != 0);
            end else begin
                step(0, $urandom_range(0, 1), cur_m, 0, 0, 0, $urandom_range(0, 3) != 0);
            end
        end
        idle(12, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
